semaforo_ctrl: RTL and testbench
================================

# semaforo_ctrl

- Four-approach traffic-light sequencer. Produces the 12-bit `semaforos` lamp vector that the on-chip logic-analyzer probe and the lamp drivers consume.
- Takes a green-time setting `ciclo_esp32` and a flash request `dest_esp32` from the ESP32 link.
- Cycles approaches 0→1→2→3→0 through green, yellow and all-red phases, with an optional flashing-yellow mode.

## Interface
- `TICKS_PER_S`, 27_000_000: clock cycles per second; benches use 4.
- `YELLOW_S`, 3: yellow duration, seconds.
- `ALLRED_S`, 1: all-red clearance duration, seconds.
- `MIN_GREEN_S`, 2: lower clamp on green duration, seconds.
- `clk  in  1`: single system clock.
- `rst  in  1`: asynchronous, active-low reset.
- `ciclo_esp32  in  5`: requested green time in seconds (0..31). Asynchronous to `clk`.
- `dest_esp32  in  1`: flash-mode request, level, active high. Asynchronous to `clk`.
- `semaforos  out  12`: approach i occupies bits [3i+2:3i] = {red, yellow, green}.
- `fase  out  2`: index of the current/last served approach.
- `flash_o  out  1`: high while in FLASH.

## Operation
- **Input synchronisation.** `ciclo_esp32` and `dest_esp32` each pass a 2-FF synchroniser (2-cycle latency). ESP32 firmware holds `ciclo_esp32` stable ≥3 cycles around a change.
- **States.**
  - INIT_RED: entered on reset; lasts ALLRED_S, then GREEN with `fase`=0.
  - GREEN: lamp of approach `fase` green, all others red.
  - YELLOW: lamp of approach `fase` yellow, all others red; lasts YELLOW_S.
  - ALLRED: all lamps red; lasts ALLRED_S.
  - FLASH: all yellow bits toggle once per second, starting ON; red and green are 0.
- **Green duration.** G = max(synchronised `ciclo_esp32`, MIN_GREEN_S), latched on GREEN entry. Changes to `ciclo_esp32` during GREEN do not affect the current phase.
- **End of ALLRED.**
  - Synchronised `dest_esp32`=1 → FLASH; `fase` is unchanged.
  - Otherwise → GREEN with `fase` = `fase`+1 mod 4 (3 wraps to 0).
- **Leaving FLASH.** Sampled only at the end of an OFF second. If `dest_esp32`=0 → ALLRED, then the normal ALLRED exit rule applies and the sequence resumes at the next approach.
- **Flash requests outside ALLRED.** `dest_esp32` asserted during GREEN or YELLOW is honoured only at the next ALLRED exit. A conflicting green is never cut short.
- **Timer.** A sub-second counter (0..TICKS_PER_S-1) and a seconds counter (5 bits) both clear on every state entry.
- **Safety invariant.** At most one approach has green or yellow set in any cycle. Red is never asserted together with yellow or green on the same approach.
- **Reset values.** `semaforos`=12'h924, `fase`=0, `flash_o`=0, state INIT_RED, counters 0.

## Timing
- All outputs are registered.
- A state lasting N seconds holds its output for exactly N×TICKS_PER_S cycles. The transition occurs on the edge after the counters reach (N-1, TICKS_PER_S-1).
- The first GREEN appears ALLRED_S×TICKS_PER_S cycles after `rst` deasserts.
- Async reset mid-phase forces `semaforos`=12'h924 immediately, without waiting for a clock edge. The sequence restarts from INIT_RED.
- Input-to-decision latency is 2 cycles (synchroniser). A request arriving ≤2 cycles before an ALLRED exit edge is missed until the next ALLRED.

## Configuration
- Macro: `SEMAFORO_FLASH_EN`.
- **Defined:** FLASH state and `dest_esp32` handling are as described above.
- **Undefined:**
  - `dest_esp32` and its synchroniser are unused.
  - FLASH is unreachable and not synthesised.
  - `flash_o` is tied to 0.
  - The normal sequence runs unconditionally.

## Test plan
All scenarios use TICKS_PER_S=4, YELLOW_S=3, ALLRED_S=1, MIN_GREEN_S=2.

1. **Reset.** Hold `rst`=0, then release. → `semaforos`=0x924 for 4 cycles, then 0x921 with `fase`=0.
2. **Normal phase sequence.** `ciclo_esp32`=5 → `semaforos`=0x921 for 20 cycles, 0x922 for 12, 0x924 for 4, then 0x90C with `fase`=1.
3. **Green clamp and mid-green change.** `ciclo_esp32`=0 → green lasts 8 cycles. Changing `ciclo_esp32` to 9 mid-green keeps the current green at 8 cycles; the next green lasts 36.
4. **Approach wrap.** Run to `fase`=3 → green 0x324. After yellow 0x524 and all-red 0x924, the sequence returns to 0x921 with `fase`=0.
5. **Flash mode.** Assert `dest_esp32` during GREEN. → The green completes; after ALLRED, 0x492 for 4 cycles and 0x000 for 4 cycles, repeating, with `flash_o`=1. Deassert → 0x924 for 4 cycles, then the next approach's green.
6. **Reset mid-yellow.** Assert `rst`=0 during 0x922. → `semaforos`=0x924 combinationally, with no clock edge needed. After release: 4 cycles of red, then 0x921.

Source files
------------

// File: rtl/semaforo_ctrl.sv
// semaforo_ctrl: four-approach traffic-light sequencer (green -> yellow -> all-red, 0->1->2->3).
// Optional flashing-yellow mode is compiled in when SEMAFORO_FLASH_EN is defined; without it
// dest_esp32 is ignored and flash_o is tied low.
module semaforo_ctrl #(
  parameter int unsigned TICKS_PER_S = 27_000_000,
  parameter int unsigned YELLOW_S    = 3,
  parameter int unsigned ALLRED_S    = 1,
  parameter int unsigned MIN_GREEN_S = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ciclo_esp32,
  input  logic        dest_esp32,
  output logic [11:0] semaforos,
  output logic [1:0]  fase,
  output logic        flash_o
);

  localparam int unsigned SubW = (TICKS_PER_S > 1) ? $clog2(TICKS_PER_S) : 1;
  localparam logic [SubW-1:0] SubLast = SubW'(TICKS_PER_S - 1);
  localparam logic [4:0] YellowLast = 5'(YELLOW_S - 1);
  localparam logic [4:0] AllRedLast = 5'(ALLRED_S - 1);
  localparam logic [4:0] MinGreen   = 5'(MIN_GREEN_S);

  // Per-approach lamp encoding is {red, yellow, green}.
  localparam logic [11:0] LampsAllRed  = 12'h924;
  localparam logic [11:0] LampsFlashOn = 12'h492;
  localparam logic [2:0]  LampGreen    = 3'b001;
  localparam logic [2:0]  LampYellow   = 3'b010;

  typedef enum logic [2:0] {
    StInitRed,
    StGreen,
    StYellow,
    StAllRed
`ifdef SEMAFORO_FLASH_EN
    , StFlash
`endif
  } state_e;

  state_e          state_q;
  logic [SubW-1:0] sub_q;
  logic [4:0]      sec_q;
  logic [4:0]      g_len_q;
  logic [4:0]      ciclo_s1_q, ciclo_s2_q;
  logic [4:0]      g_new;
  logic            sub_end;

  // All approaches red except approach idx, which shows rgb.
  function automatic logic [11:0] lamp_one(input logic [1:0] idx, input logic [2:0] rgb);
    logic [11:0] v;
    v = LampsAllRed;
    unique case (idx)
      2'd0: v[2:0]  = rgb;
      2'd1: v[5:3]  = rgb;
      2'd2: v[8:6]  = rgb;
      2'd3: v[11:9] = rgb;
      default: v = LampsAllRed;
    endcase
    return v;
  endfunction

  // Two-flop synchroniser for the green-time setting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ciclo_s1_q <= '0;
      ciclo_s2_q <= '0;
    end else begin
      ciclo_s1_q <= ciclo_esp32;
      ciclo_s2_q <= ciclo_s1_q;
    end
  end

`ifdef SEMAFORO_FLASH_EN
  logic dest_s1_q, dest_s2_q;
  logic flash_q;

  // Two-flop synchroniser for the flash request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_s1_q <= 1'b0;
      dest_s2_q <= 1'b0;
    end else begin
      dest_s1_q <= dest_esp32;
      dest_s2_q <= dest_s1_q;
    end
  end

  assign flash_o = flash_q;
`else
  logic unused_dest;
  assign unused_dest = dest_esp32;
  assign flash_o     = 1'b0;
`endif

  // Green length for the phase about to start, clamped to the minimum.
  always_comb begin
    g_new = ciclo_s2_q;
    if (ciclo_s2_q < MinGreen) g_new = MinGreen;
  end

  assign sub_end = (sub_q == SubLast);

  // Sequencer: state, timers and registered lamp/phase outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StInitRed;
      sub_q     <= '0;
      sec_q     <= '0;
      g_len_q   <= MinGreen;
      semaforos <= LampsAllRed;
      fase      <= 2'd0;
`ifdef SEMAFORO_FLASH_EN
      flash_q   <= 1'b0;
`endif
    end else begin
      // Free-running timer; every state change below clears it.
      if (sub_end) begin
        sub_q <= '0;
        sec_q <= sec_q + 5'd1;
      end else begin
        sub_q <= sub_q + 1'b1;
      end

      case (state_q)
        StInitRed: begin
          if (sub_end && sec_q == AllRedLast) begin
            state_q   <= StGreen;
            fase      <= 2'd0;
            semaforos <= lamp_one(2'd0, LampGreen);
            g_len_q   <= g_new;
            sub_q     <= '0;
            sec_q     <= '0;
          end
        end
        StGreen: begin
          if (sub_end && sec_q == g_len_q - 5'd1) begin
            state_q   <= StYellow;
            semaforos <= lamp_one(fase, LampYellow);
            sub_q     <= '0;
            sec_q     <= '0;
          end
        end
        StYellow: begin
          if (sub_end && sec_q == YellowLast) begin
            state_q   <= StAllRed;
            semaforos <= LampsAllRed;
            sub_q     <= '0;
            sec_q     <= '0;
          end
        end
        StAllRed: begin
          if (sub_end && sec_q == AllRedLast) begin
            sub_q <= '0;
            sec_q <= '0;
`ifdef SEMAFORO_FLASH_EN
            if (dest_s2_q) begin
              state_q   <= StFlash;
              semaforos <= LampsFlashOn;
              flash_q   <= 1'b1;
            end else
`endif
            begin
              state_q   <= StGreen;
              fase      <= fase + 2'd1;
              semaforos <= lamp_one(fase + 2'd1, LampGreen);
              g_len_q   <= g_new;
            end
          end
        end
`ifdef SEMAFORO_FLASH_EN
        StFlash: begin
          // Even seconds are ON, odd seconds OFF; exit is only considered after an OFF second.
          if (sub_end) begin
            if (sec_q[0]) begin
              if (!dest_s2_q) begin
                state_q   <= StAllRed;
                semaforos <= LampsAllRed;
                flash_q   <= 1'b0;
                sub_q     <= '0;
                sec_q     <= '0;
              end else begin
                semaforos <= LampsFlashOn;
              end
            end else begin
              semaforos <= 12'h000;
            end
          end
        end
`endif
        default: begin
          state_q   <= StInitRed;
          semaforos <= LampsAllRed;
          sub_q     <= '0;
          sec_q     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_semaforo_ctrl.sv
// tb_semaforo_ctrl: randomized scoreboard bench for semaforo_ctrl.
// The stimulus process walks the light sequence at phase level, pushing each expected lamp
// segment (value, phase, flash flag, length in cycles); a monitor measures segments on the DUT
// outputs and pops/compares them.
module tb_semaforo_ctrl;

  localparam int unsigned T = 4;
`ifdef SEMAFORO_FLASH_EN
  localparam bit FlashEn = 1'b1;
`else
  localparam bit FlashEn = 1'b0;
`endif

  typedef struct {
    logic [11:0] lamps;
    logic [1:0]  fase;
    logic        flash;
    int          len;
  } seg_t;

  logic        clk;
  logic        rst;
  logic [4:0]  ciclo_esp32;
  logic        dest_esp32;
  logic [11:0] semaforos;
  logic [1:0]  fase;
  logic        flash_o;

  seg_t exp_q[$];
  int   checks;
  int   errors;
  bit   done;
  int   ciclo_cur;

  semaforo_ctrl #(
    .TICKS_PER_S(T),
    .YELLOW_S   (3),
    .ALLRED_S   (1),
    .MIN_GREEN_S(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ciclo_esp32(ciclo_esp32),
    .dest_esp32 (dest_esp32),
    .semaforos  (semaforos),
    .fase       (fase),
    .flash_o    (flash_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lamp vector with approach idx showing color and every other approach red.
  function automatic logic [11:0] lamps_for(input int idx, input logic [2:0] color);
    logic [11:0] v;
    v = '0;
    for (int a = 0; a < 4; a++) v[3*a +: 3] = (a == idx) ? color : 3'b100;
    return v;
  endfunction

  task automatic push_seg(input logic [11:0] l, input int f, input bit fl, input int len);
    seg_t s;
    s.lamps = l;
    s.fase  = 2'(f);
    s.flash = fl;
    s.len   = len;
    exp_q.push_back(s);
  endtask

  task automatic check_now(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Green for approach i; mid-phase, ciclo changes (next_ciclo<0 means random) and an optional
  // flash request is raised.
  task automatic do_green(input int i, input int next_ciclo, input bit req_flash);
    int len, off;
    len = ((ciclo_cur < 2) ? 2 : ciclo_cur) * T;
    push_seg(lamps_for(i, 3'b001), i, 1'b0, len);
    off = $urandom_range(len - 1, 1);
    repeat (off) @(posedge clk);
    #1;
    ciclo_cur   = (next_ciclo < 0) ? int'($urandom_range(9, 0)) : next_ciclo;
    ciclo_esp32 = 5'(ciclo_cur);
    if (req_flash) dest_esp32 = 1'b1;
    repeat (len - off) @(posedge clk);
  endtask

  task automatic do_flash(input int i);
    int k;
    k = $urandom_range(3, 1);
    for (int p = 0; p < k; p++) begin
      push_seg(12'h492, i, 1'b1, T);
      if (p == k - 1) begin
        #1;
        dest_esp32 = 1'b0;
      end
      repeat (T) @(posedge clk);
      push_seg(12'h000, i, 1'b1, T);
      repeat (T) @(posedge clk);
    end
    push_seg(12'h924, i, 1'b0, T);
    repeat (T) @(posedge clk);
  endtask

  task automatic reset_mid_yellow(input int i);
    push_seg(lamps_for(i, 3'b010), i, 1'b0, 3 * T);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check_now("async_reset_lamps", 32'(semaforos), 32'h924);
    check_now("async_reset_fase", 32'(fase), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_now("held_reset_lamps", 32'(semaforos), 32'h924);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_seg(12'h924, 0, 1'b0, T);
    repeat (T) @(posedge clk);
  endtask

  // Monitor: segment lengths/values against the scoreboard, plus the lamp safety invariant.
  initial begin : monitor
    logic [14:0] cur;
    int          cnt;
    bit          cur_valid;
    seg_t        e;
    int          act;
    bit          bad;
    cur_valid = 1'b0;
    cnt       = 0;
    forever begin
      @(negedge clk);
      if (!done) begin
        if (!rst) begin
          cur_valid = 1'b0;
        end else begin
          act = 0;
          bad = 1'b0;
          for (int a = 0; a < 4; a++) begin
            if (semaforos[3*a+2] && (semaforos[3*a+1] || semaforos[3*a])) bad = 1'b1;
            if (semaforos[3*a+1] || semaforos[3*a]) act++;
          end
          checks++;
          if (bad || act > 1) begin
            errors++;
            $display("FAIL lamp_invariant got=%h want=safe", semaforos);
          end
          if (!cur_valid) begin
            cur       = {semaforos, fase, flash_o};
            cnt       = 1;
            cur_valid = 1'b1;
          end else if ({semaforos, fase, flash_o} == cur) begin
            cnt++;
          end else begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL seg_unexpected got lamps=%h len=%0d want=none", cur[14:3], cnt);
            end else begin
              e = exp_q.pop_front();
              if (cur !== {e.lamps, e.fase, e.flash}) begin
                errors++;
                $display("FAIL seg_value got lamps=%h fase=%0d flash=%0b want lamps=%h fase=%0d flash=%0b",
                         cur[14:3], cur[2:1], cur[0], e.lamps, e.fase, e.flash);
              end
              checks++;
              if (cnt != e.len) begin
                errors++;
                $display("FAIL seg_length lamps=%h got=%0d want=%0d", e.lamps, cnt, e.len);
              end
            end
            cur = {semaforos, fase, flash_o};
            cnt = 1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    errors++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin : stimulus
    int  i;
    bit  fl;
    int  nxt;
    checks      = 0;
    errors      = 0;
    done        = 1'b0;
    rst         = 1'b0;
    dest_esp32  = 1'b0;
    ciclo_cur   = 5;
    ciclo_esp32 = 5'd5;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_lamps", 32'(semaforos), 32'h924);
    check_now("reset_fase", 32'(fase), 32'd0);
    check_now("reset_flash", 32'(flash_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_seg(12'h924, 0, 1'b0, T);
    repeat (T) @(posedge clk);

    i = 0;
    for (int n = 0; n < 14; n++) begin
      fl = (n == 4) || ((n >= 3) && (n != 6) && ($urandom_range(3, 0) == 0));
      nxt = (n == 0) ? 0 : (n == 1) ? 9 : -1;
      do_green(i, nxt, fl);
      if (n == 6) begin
        reset_mid_yellow(i);
        i = 0;
      end else begin
        push_seg(lamps_for(i, 3'b010), i, 1'b0, 3 * T);
        repeat (3 * T) @(posedge clk);
        push_seg(12'h924, i, 1'b0, T);
        repeat (T) @(posedge clk);
        if (fl && FlashEn) do_flash(i);
        #1;
        dest_esp32 = 1'b0;
        i = (i + 1) % 4;
      end
    end

    @(negedge clk);
    #1;
    check_now("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    done = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
